program_loader: RTL and testbench

//  Byte-stream boot loader upstream of top_level. Accepts a framed program over a

---
 rtl/cpu_defs_pkg.sv | 31 +++
 rtl/program_loader.sv | 141 ++++++++++++++
 tb/tb_program_loader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: boot-loader FSM states and instruction field positions.
// Imported by the loader and by any block that decodes instruction words.
package cpu_defs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_HI,
        ST_LO,
        ST_WR,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_t;

    // Instruction word layout: [15:12] op, [11:8] mem_op, [7:4] left, [3:0] right
    localparam int OP_MSB     = 15;
    localparam int OP_LSB     = 12;
    localparam int MEM_OP_MSB = 11;
    localparam int MEM_OP_LSB = 8;
    localparam int LEFT_MSB   = 7;
    localparam int LEFT_LSB   = 4;
    localparam int RIGHT_MSB  = 3;
    localparam int RIGHT_LSB  = 0;

    // States in which the loader consumes a stream byte
    function automatic logic accepts_byte(input loader_state_t s);
        return (s == ST_LEN) || (s == ST_HI) || (s == ST_LO) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/program_loader.sv
// Byte-stream boot loader: parses N, {hi,lo} x N, CSUM, writes each word into
// CPU memory and releases the CPU reset only after a load with a good checksum.
module program_loader
    import cpu_defs_pkg::*;
#(
    parameter int DATA_SIZE = 16,
    parameter int ADDR_SIZE = 5,
    parameter int BYTE_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BYTE_W-1:0]    rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 W,
    output logic                 OVERWRITE,
    output logic [ADDR_SIZE-1:0] ADDR,
    output logic [DATA_SIZE-1:0] DATA_WR,
    output logic                 cpu_rstn,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    // One extra bit so a full-memory load (N == 2**ADDR_SIZE) is representable
    localparam int                CNT_W = ADDR_SIZE + 1;
    localparam logic [BYTE_W-1:0] MAX_N = BYTE_W'(2 ** ADDR_SIZE);

    loader_state_t     state, state_nx;
    logic              xfer;
    logic              len_bad;
    logic              csum_ok;
    logic [CNT_W-1:0]  cnt;
    logic [BYTE_W-1:0] hi_byte;
    logic [BYTE_W-1:0] csum;

    assign xfer    = rx_valid && rx_ready;
    assign len_bad = (rx_data == '0) || (rx_data > MAX_N);
    assign csum_ok = (rx_data == csum);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_LEN;
            ST_LEN:   if (xfer)  state_nx = len_bad ? ST_ERR : ST_HI;
            ST_HI:    if (xfer)  state_nx = ST_LO;
            ST_LO:    if (xfer)  state_nx = ST_WR;
            ST_WR:    state_nx = (cnt == CNT_W'(1)) ? ST_CSUM : ST_HI;
            ST_CSUM:  if (xfer)  state_nx = csum_ok ? ST_DONE : ST_ERR;
            ST_DONE,
            ST_ERR:   if (start) state_nx = ST_LEN;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Registered outputs and control: strobes are derived from the next state so
    // they line up with the cycle the FSM spends in that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ready  <= 1'b0;
            W         <= 1'b0;
            OVERWRITE <= 1'b0;
            ADDR      <= '0;
            DATA_WR   <= '0;
            cpu_rstn  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
        end else begin
            rx_ready  <= accepts_byte(state_nx);
            W         <= (state_nx == ST_WR);
            OVERWRITE <= (state_nx == ST_WR);
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        cpu_rstn <= 1'b0;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_LEN: begin
                    if (xfer) begin
                        if (len_bad) begin
                            err  <= 1'b1;
                            busy <= 1'b0;
                        end else begin
                            cnt  <= rx_data[CNT_W-1:0];
                            ADDR <= '0;
                        end
                    end
                end
                ST_LO: begin
                    if (xfer) DATA_WR <= {hi_byte, rx_data};
                end
                ST_WR: begin
                    ADDR <= ADDR + ADDR_SIZE'(1);
                    cnt  <= cnt - CNT_W'(1);
                end
                ST_CSUM: begin
                    if (xfer) begin
                        busy <= 1'b0;
                        if (csum_ok) begin
                            done     <= 1'b1;
                            cpu_rstn <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Byte datapath: running checksum and held high byte
    always_ff @(posedge clk) begin
        if (xfer) begin
            case (state)
                ST_LEN:  csum <= rx_data;
                ST_HI: begin
                    hi_byte <= rx_data;
                    csum    <= csum ^ rx_data;
                end
                ST_LO:   csum <= csum ^ rx_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as frames are
// built and retired against every W pulse.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        W;
    logic        OVERWRITE;
    logic [4:0]  ADDR;
    logic [15:0] DATA_WR;
    logic        cpu_rstn;
    logic        busy;
    logic        done;
    logic        err;

    int n_chk  = 0;
    int n_pass = 0;

    logic [20:0] exp_q[$];
    logic [7:0]  bytes_q[$];
    logic [15:0] words_buf[32];
    int          bidx;

    program_loader #(.DATA_SIZE(16), .ADDR_SIZE(5), .BYTE_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .W(W), .OVERWRITE(OVERWRITE), .ADDR(ADDR), .DATA_WR(DATA_WR),
        .cpu_rstn(cpu_rstn), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Retire one expected write per W pulse
    always @(negedge clk) begin
        if (W === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_w", {11'd0, ADDR, DATA_WR}, 32'hFFFF_FFFF);
            end else begin
                logic [20:0] e;
                e = exp_q.pop_front();
                check("w_addr", 32'(ADDR), 32'(e[20:16]));
                check("w_data", 32'(DATA_WR), 32'(e[15:0]));
                check("w_ovw", 32'(OVERWRITE), 32'd1);
                check("w_rdy0", 32'(rx_ready), 32'd0);
            end
        end
    end

    task automatic build_frame(input logic [7:0] n, input int nwords,
                               input logic [7:0] cs, input int nexp);
        bytes_q.delete();
        bidx = 0;
        bytes_q.push_back(n);
        for (int k = 0; k < nwords; k++) begin
            bytes_q.push_back(words_buf[k][15:8]);
            bytes_q.push_back(words_buf[k][7:0]);
        end
        bytes_q.push_back(cs);
        for (int k = 0; k < nexp; k++) exp_q.push_back({5'(k), words_buf[k]});
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int waited;
        if (gaps) begin
            rx_valid = 1'b0;
            rx_data  = 8'hxx;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        waited   = 0;
        while (!rx_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready) begin
            check("rx_timeout", 32'(waited), 32'd0);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic send_n(input int count, input bit gaps);
        for (int i = 0; i < count && bidx < bytes_q.size(); i++) begin
            send_byte(bytes_q[bidx], gaps);
            bidx++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int c = 0;
        rx_valid = 1'b0;
        while (busy && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_t1(input logic [7:0] cs, input bit gaps);
        words_buf[0] = 16'h1012;
        words_buf[1] = 16'h2023;
        words_buf[2] = 16'h3001;
        build_frame(8'h03, 3, cs, 3);
        pulse_start();
        send_n(bytes_q.size(), gaps);
        wait_idle();
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_w",      32'(W),         32'd0);
        check("rst_ovw",    32'(OVERWRITE), 32'd0);
        check("rst_addr",   32'(ADDR),      32'd0);
        check("rst_data",   32'(DATA_WR),   32'd0);
        check("rst_busy",   32'(busy),      32'd0);
        check("rst_done",   32'(done),      32'd0);
        check("rst_err",    32'(err),       32'd0);
        check("rst_ready",  32'(rx_ready),  32'd0);
        check("rst_cpurst", 32'(cpu_rstn),  32'd0);

        // start coincident with rst is dropped
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_wins_busy", 32'(busy), 32'd0);

        // Test 1: good frame, full rate
        load_t1(8'h33, 1'b0);
        check("t1_done",   32'(done),     32'd1);
        check("t1_err",    32'(err),      32'd0);
        check("t1_cpurst", 32'(cpu_rstn), 32'd1);
        check("t1_ready",  32'(rx_ready), 32'd0);
        check("t1_addr",   32'(ADDR),     32'd3);

        // Test 2: bad checksum
        load_t1(8'h34, 1'b0);
        check("t2_err",    32'(err),      32'd1);
        check("t2_done",   32'(done),     32'd0);
        check("t2_cpurst", 32'(cpu_rstn), 32'd0);

        // Test 3: illegal lengths
        build_frame(8'h00, 0, 8'h00, 0);
        pulse_start();
        send_n(1, 1'b0);
        wait_idle();
        check("t3_n0_err",  32'(err),  32'd1);
        check("t3_n0_done", 32'(done), 32'd0);
        build_frame(8'h21, 0, 8'h00, 0);
        pulse_start();
        send_n(1, 1'b0);
        wait_idle();
        check("t3_n33_err",   32'(err),      32'd1);
        check("t3_n33_ready", 32'(rx_ready), 32'd0);

        // Test 4: random valid gaps
        load_t1(8'h33, 1'b1);
        check("t4_done", 32'(done), 32'd1);
        check("t4_err",  32'(err),  32'd0);

        // Test 5: full 32-word load; xor of identical hi/lo bytes cancels, so CSUM = N
        for (int i = 0; i < 32; i++) words_buf[i] = 16'(i * 16'h0101);
        build_frame(8'h20, 32, 8'h20, 32);
        pulse_start();
        send_n(bytes_q.size(), 1'b0);
        wait_idle();
        check("t5_done",   32'(done),     32'd1);
        check("t5_cpurst", 32'(cpu_rstn), 32'd1);
        check("t5_wrap",   32'(ADDR),     32'd0);

        // Test 6: start ignored while busy, then reset after two words
        words_buf[0] = 16'h1012;
        words_buf[1] = 16'h2023;
        words_buf[2] = 16'h3001;
        build_frame(8'h03, 3, 8'h33, 2);
        pulse_start();
        send_n(3, 1'b0);
        fork
            begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join_none
        send_n(2, 1'b0);
        check("t6_busy_held", 32'(busy), 32'd1);
        rst = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("t6_w",      32'(W),        32'd0);
        check("t6_busy",   32'(busy),     32'd0);
        check("t6_cpurst", 32'(cpu_rstn), 32'd0);
        check("t6_sb",     32'(exp_q.size()), 32'd0);
        @(negedge clk);
        load_t1(8'h33, 1'b0);
        check("t6_rerun_done",   32'(done),     32'd1);
        check("t6_rerun_cpurst", 32'(cpu_rstn), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
